// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
//   Control for the 8-point FFT datapath. It counts accepted samples and
//   fires frame_load once a full frame sits in the serial-to-parallel stage.
//   It then waits PIPE_LAT cycles for the FFT pipeline and walks the output
//   serializer through bins 0..7 under a valid/ready handshake. A frame that
//   completes while the previous one is still in flight is dropped, and the
//   sticky overrun flag records the drop.
//
// Ports
//   clk, rst      : system clock, synchronous active-high reset
//   enable        : sample acceptance enable
//   sample_valid  : new sample presented this cycle
//   out_ready     : downstream consumes the current bin this cycle
//   clr_ovr       : clears the sticky overrun flag
//   load_en       : shift enable to the S2P stage (combinational)
//   frame_load    : one-cycle pulse that latches the parallel samples
//   fft_busy      : frame in flight (COMPUTE or EMIT)
//   bin_valid     : bin_index is valid
//   bin_index     : current output bin
//   frame_last    : bin_valid on bin 7
//   overrun       : sticky flag, a complete frame was dropped
//   frame_count   : frames loaded since reset (wraps)
module fft_frame_sequencer #(
    parameter int N_PTS    = 8,
    parameter int PIPE_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       sample_valid,
    input  logic       out_ready,
    input  logic       clr_ovr,
    output logic       load_en,
    output logic       frame_load,
    output logic       fft_busy,
    output logic       bin_valid,
    output logic [2:0] bin_index,
    output logic       frame_last,
    output logic       overrun,
    output logic [7:0] frame_count
);

    localparam logic [2:0] LAST     = 3'(N_PTS - 1);
    localparam logic [3:0] LAT_INIT = 4'(PIPE_LAT - 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, EMIT} state_t;

    state_t     state, state_n;
    logic [2:0] samp_cnt;
    logic [3:0] lat_cnt, lat_n;
    logic [2:0] idx_n;
    logic       bv_n, fl_n, ovr_n;
    logic [7:0] cnt_n;
    logic       accept, frame_done, free, start, drop;

    assign accept     = sample_valid & enable;
    assign load_en    = accept & ~rst;
    assign frame_done = accept & (samp_cnt == LAST);

    // The FSM can take a new frame when idle, or on the very cycle the last
    // bin is being handed off.
    assign free  = (state == IDLE) ||
                   (state == EMIT && out_ready && bin_index == LAST);
    assign start = frame_done & free;
    assign drop  = frame_done & ~free;

    assign fft_busy   = (state != IDLE);
    assign frame_last = bin_valid & (bin_index == LAST);

    // The sample counter runs independently of the FSM; dropped frames still
    // wrap it so the next frame boundary stays aligned.
    always_ff @(posedge clk) begin
        if (rst)
            samp_cnt <= '0;
        else if (accept)
            samp_cnt <= samp_cnt + 3'd1;
    end

    always_comb begin
        state_n = state;
        lat_n   = lat_cnt;
        idx_n   = bin_index;
        bv_n    = bin_valid;
        fl_n    = start;
        cnt_n   = start ? frame_count + 8'd1 : frame_count;
        ovr_n   = drop ? 1'b1 : (clr_ovr ? 1'b0 : overrun);
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = COMPUTE;
                    lat_n   = LAT_INIT;
                end
            end
            COMPUTE: begin
                if (lat_cnt == 4'd0) begin
                    state_n = EMIT;
                    idx_n   = '0;
                    bv_n    = 1'b1;
                end else begin
                    lat_n = lat_cnt - 4'd1;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (bin_index == LAST) begin
                        bv_n  = 1'b0;
                        idx_n = '0;
                        if (start) begin
                            state_n = COMPUTE;
                            lat_n   = LAT_INIT;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        idx_n = bin_index + 3'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            bin_index   <= '0;
            bin_valid   <= 1'b0;
            frame_load  <= 1'b0;
            frame_count <= '0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_n;
            lat_cnt     <= lat_n;
            bin_index   <= idx_n;
            bin_valid   <= bv_n;
            frame_load  <= fl_n;
            frame_count <= cnt_n;
            overrun     <= ovr_n;
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer (PIPE_LAT = 4). Inputs change 1 ns
// after a rising edge; outputs are checked at that point, so registered
// outputs reflect the edge just taken.
module tb_fft_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst, enable, sample_valid, out_ready, clr_ovr;
    logic       load_en, frame_load, fft_busy, bin_valid, frame_last, overrun;
    logic [2:0] bin_index;
    logic [7:0] frame_count;

    int errors = 0;
    int checks = 0;

    fft_frame_sequencer #(.N_PTS(8), .PIPE_LAT(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
        .out_ready(out_ready), .clr_ovr(clr_ovr), .load_en(load_en),
        .frame_load(frame_load), .fft_busy(fft_busy), .bin_valid(bin_valid),
        .bin_index(bin_index), .frame_last(frame_last), .overrun(overrun),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Eight back-to-back accepts; frame_load must stay low until the last.
    task automatic send_frame();
        for (int i = 0; i < 8; i++) begin
            sample_valid = 1'b1;
            enable       = 1'b1;
            tick();
            if (i < 7) chk("no_early_load", frame_load, 0);
        end
        sample_valid = 1'b0;
    endtask

    // Walk bins from..7 with out_ready high; ends one cycle after bin 7.
    task automatic drain_bins(input int from, input logic ovr_exp);
        for (int b = from; b < 8; b++) begin
            chk("bin_valid", bin_valid, 1);
            chk("bin_index", bin_index, b);
            chk("frame_last", frame_last, (b == 7) ? 1 : 0);
            chk("ovr_hold", overrun, ovr_exp);
            tick();
        end
        chk("valid_drop", bin_valid, 0);
        chk("busy_drop", fft_busy, 0);
    endtask

    task automatic wait_lat();
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("lat_no_valid", bin_valid, 0);
            chk("lat_no_load", frame_load, 0);
            chk("lat_busy", fft_busy, 1);
        end
        tick();
    endtask

    initial begin
        logic [12:0] en_pat;
        int          loads;

        // Reset with samples presented
        rst = 1'b1; sample_valid = 1'b1; enable = 1'b1; out_ready = 1'b1; clr_ovr = 1'b0;
        #1;
        chk("load_en_rst", load_en, 0);
        tick(); tick();
        chk("rst_load_en", load_en, 0);
        chk("rst_frame_load", frame_load, 0);
        chk("rst_busy", fft_busy, 0);
        chk("rst_valid", bin_valid, 0);
        chk("rst_index", bin_index, 0);
        chk("rst_last", frame_last, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_count", frame_count, 0);
        rst = 1'b0; sample_valid = 1'b0;
        #1;
        chk("load_en_idle", load_en, 0);

        // Nominal frame
        sample_valid = 1'b1; #1;
        chk("load_en_on", load_en, 1);
        send_frame();
        chk("nom_load", frame_load, 1);
        chk("nom_busy", fft_busy, 1);
        chk("nom_count", frame_count, 1);
        wait_lat();
        drain_bins(0, 1'b0);
        chk("nom_load_once", frame_load, 0);

        // Backpressure at bin 2
        send_frame();
        chk("bp_count", frame_count, 2);
        wait_lat();
        chk("bp_b0", bin_index, 0);
        tick();
        chk("bp_b1", bin_index, 1);
        tick();
        chk("bp_b2", bin_index, 2);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_idx", bin_index, 2);
            chk("bp_hold_valid", bin_valid, 1);
        end
        out_ready = 1'b1;
        tick();
        drain_bins(3, 1'b0);

        // Overrun: second frame completes during EMIT (bin 3)
        send_frame();
        chk("ovr_first_load", frame_load, 1);
        chk("ovr_first_count", frame_count, 3);
        for (int j = 1; j <= 8; j++) begin
            sample_valid = 1'b1;
            tick();
            chk("ovr_no_load", frame_load, 0);
        end
        sample_valid = 1'b0;
        chk("ovr_set", overrun, 1);
        chk("ovr_count", frame_count, 3);
        drain_bins(4, 1'b1);
        tick();
        chk("ovr_sticky", overrun, 1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("ovr_clear", overrun, 0);

        // Boundary: 8th accept coincides with accepted bin 7
        send_frame();
        chk("bnd_count_a", frame_count, 4);
        wait_lat();
        chk("bnd_b0", bin_index, 0);
        for (int j = 0; j < 8; j++) begin
            sample_valid = 1'b1;
            if (j == 7) chk("bnd_last_aligned", frame_last, 1);
            tick();
        end
        sample_valid = 1'b0;
        chk("bnd_load", frame_load, 1);
        chk("bnd_ovr", overrun, 0);
        chk("bnd_count_b", frame_count, 5);
        chk("bnd_busy", fft_busy, 1);
        chk("bnd_valid_gap", bin_valid, 0);
        wait_lat();
        drain_bins(0, 1'b0);

        // Enable gating: 13 valid cycles, enable low on 5
        en_pat = 13'b1010110101101;
        loads  = 0;
        for (int i = 0; i < 13; i++) begin
            sample_valid = 1'b1;
            enable       = en_pat[12 - i];
            #1;
            chk("gate_load_en", load_en, en_pat[12 - i]);
            tick();
            if (frame_load) loads++;
        end
        chk("gate_one_frame", loads, 1);
        chk("gate_load_last", frame_load, 1);
        chk("gate_count", frame_count, 6);
        enable = 1'b1;

        // Partial accepts during COMPUTE, then reset mid-operation
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        #1;
        chk("mid_load_en_rst", load_en, 0);
        tick();
        rst = 1'b0; sample_valid = 1'b0;
        chk("mid_busy", fft_busy, 0);
        chk("mid_count", frame_count, 0);
        chk("mid_load", frame_load, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("mid_no_valid", bin_valid, 0);
        end
        send_frame();
        chk("mid_fresh_load", frame_load, 1);
        chk("mid_fresh_count", frame_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
